ysyx_22041211_lsu_hs: RTL
=========================

Name: ysyx_22041211_lsu_hs

Overview:
- Next-generation load/store unit sitting between EXU and WBU.
- Uses valid/ready handshakes on upstream, memory and writeback sides, in place of the fixed-timing IFU-valid chain.
- Memory is reached through a split request/response port with variable latency, so the same block drives SRAM now and a bus bridge later.
- Adds byte-lane alignment of sub-word accesses, write strobes, misalignment detection, bus-error reporting and a parametrised data width.

Parameters:
- DATA_LEN, 32, register/bus data width; legal values 32 or 64.
- ADDR_LEN, 32, memory address width.
- STRB_LEN, DATA_LEN/8, write strobe width (derived, not overridden).
- OFF_LEN, log2(STRB_LEN), byte-offset bits of the address (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid_i  in  1  EXU result valid
- in_ready_o  out  1  LSU can accept
- alu_result_i  in  DATA_LEN  address, or result for non-memory ops
- mem_wdata_i  in  DATA_LEN  store data (rs2)
- load_type_i  in  3  load encoding
- store_type_i  in  2  store encoding
- wd_i  in  1  register write enable
- wreg_i  in  5  destination register
- csr_wdata_i  in  DATA_LEN  CSR write data, passed through
- req_valid_o  out  1  memory request valid
- req_ready_i  in  1  memory request accepted
- req_wen_o  out  1  1 = write
- req_addr_o  out  ADDR_LEN  word-aligned address (low OFF_LEN bits zero)
- req_wdata_o  out  DATA_LEN  lane-shifted store data
- req_wstrb_o  out  STRB_LEN  byte strobes (0 for reads)
- resp_valid_i  in  1  memory response valid
- resp_ready_o  out  1  LSU accepts response
- resp_rdata_i  in  DATA_LEN  raw read data
- resp_err_i  in  1  access fault
- out_valid_o  out  1  writeback bundle valid
- out_ready_i  in  1  WBU accepts
- wd_o  out  1  register write enable
- wreg_o  out  5  destination register
- wdata_o  out  DATA_LEN  writeback data
- csr_wdata_o  out  DATA_LEN  CSR data
- memory_inst_o  out  1  captured op is a load or store
- misalign_o  out  1  exception: misaligned access
- access_err_o  out  1  exception: bus error

Behaviour:
- Reset: state IDLE; in_ready_o=1; req_valid_o, resp_ready_o, out_valid_o, misalign_o, access_err_o, memory_inst_o = 0; data outputs 0.
- State machine: IDLE, REQ, RESP, DONE. in_ready_o = (state==IDLE).
- IDLE: on in_valid_i & in_ready_o, capture all inputs.
  - Non-memory op (load_type=0, store_type=0) -> DONE.
  - Misaligned access -> DONE with misalign_o=1. Half-word needs addr[0]=0; word needs addr[1:0]=0; byte is always aligned.
  - Otherwise -> REQ.
- REQ: req_valid_o=1; all req_* held stable until req_ready_i; then -> RESP.
- RESP: resp_ready_o=1. On resp_valid_i: latch the aligned result, set access_err_o=resp_err_i, -> DONE. Stores also wait for their response (write ack).
- DONE: out_valid_o=1; outputs held until out_ready_i; then -> IDLE.
- No back-to-back accept in the same cycle as the out handshake: IDLE is re-entered first.
- Latency, with zero-wait memory and WBU ready:
  - Non-memory op: out_valid_o in cycle T+1 after accept in T.
  - Load/store: req_valid_o in T+1, response earliest T+2, out_valid_o in T+3.
- Store lanes:
  - off = addr[OFF_LEN-1:0].
  - SB: wdata byte replicated to all lanes; wstrb = 1<<off.
  - SH: half-word replicated; wstrb = 2'b11<<off.
  - SW: word replicated; wstrb = 4'hF<<off.
- Load lanes: rdata shifted right by off*8, then LB/LH/LW sign-extended and LBU/LHU zero-extended to DATA_LEN. With DATA_LEN=64, LW sign-extends to 64.
- wdata_o = aligned load data for loads, otherwise the captured alu_result.
- Exceptions: on misalign or bus error, wd_o is forced to 0; stores with misalign issue no request.
- memory_inst_o is high from capture until the out handshake whenever the captured op is a load or store.
- Error flags clear when leaving DONE.
- Reset mid-operation: returns to IDLE next edge and drops any outstanding transaction. After reset, a stale resp_valid_i is ignored because resp_ready_o=0.
- Unknown load/store encodings are treated as non-memory.

Decomposition:
- ysyx_22041211_define.v holds these constants:
  - LOAD_NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5
  - STORE_NONE=0, SB=1, SH=2, SW=3
  - state encodings IDLE=0, REQ=1, RESP=2, DONE=3
- One combinational sub-module, ysyx_22041211_lsu_align: store lane/strobe generation and load shift/extend, parametrised by DATA_LEN.

Test Plan:
- Non-memory op: alu_result=0x1234, wd=1, wreg=5, out_ready=1 -> out_valid in T+1; wdata_o=0x1234; no req_valid.
- SB: addr 0x80000003, data 0xAB -> req_addr=0x80000000, wstrb=4'b1000, wdata=0xABABABAB; out_valid after response; wd_o=0.
- LB then LBU: addr 0x80000002, memory returns 0x00F00000 -> wdata 0xFFFFFFF0 (LB) and 0x000000F0 (LBU).
- Misaligned LH at 0x80000001 -> no req_valid; misalign_o=1, wd_o=0, out_valid in T+1.
- Backpressure: req_ready low 3 cycles, resp 2 cycles late, out_ready low 2 cycles -> req_*/out_* stable throughout; in_ready low until DONE handshake.
- Reset asserted in RESP, then resp_valid pulsed -> IDLE; resp_ready=0; out_valid never rises; next op completes normally. Also: resp_err=1 on LW -> access_err_o=1, wd_o=0.

Source files
------------

// File: rtl/ysyx_22041211_lsu_hs_pkg.sv
// Shared encodings for the handshaked load/store unit: load/store op codes,
// FSM states and the alignment rule used at capture time.
package ysyx_22041211_lsu_hs_pkg;

  localparam logic [2:0] LOAD_NONE = 3'd0;
  localparam logic [2:0] LB        = 3'd1;
  localparam logic [2:0] LBU       = 3'd2;
  localparam logic [2:0] LH        = 3'd3;
  localparam logic [2:0] LHU       = 3'd4;
  localparam logic [2:0] LW        = 3'd5;

  localparam logic [1:0] STORE_NONE = 2'd0;
  localparam logic [1:0] SB         = 2'd1;
  localparam logic [1:0] SH         = 2'd2;
  localparam logic [1:0] SW         = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  function automatic logic is_load(input logic [2:0] load_type);
    return (load_type >= LB) && (load_type <= LW);
  endfunction

  // Bytes never fault; half-words need bit 0 clear, words need bits 1:0 clear.
  function automatic logic is_misaligned(input logic [2:0] load_type,
                                         input logic [1:0] store_type,
                                         input logic [1:0] off);
    logic half;
    logic word;
    half = (load_type == LH) || (load_type == LHU) || (store_type == SH);
    word = (load_type == LW) || (store_type == SW);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/ysyx_22041211_lsu_align.sv
// Byte-lane steering: store data replication and strobes, load shift and
// sign/zero extension. Purely combinational.
module ysyx_22041211_lsu_align
  import ysyx_22041211_lsu_hs_pkg::*;
#(
  parameter int DATA_LEN = 32,
  localparam int STRB_LEN = DATA_LEN / 8,
  localparam int OFF_LEN = $clog2(STRB_LEN)
) (
  input  logic [OFF_LEN-1:0]  st_off,
  input  logic [1:0]          store_type,
  input  logic [DATA_LEN-1:0] st_data,
  output logic [DATA_LEN-1:0] st_wdata,
  output logic [STRB_LEN-1:0] st_wstrb,
  input  logic [OFF_LEN-1:0]  ld_off,
  input  logic [2:0]          load_type,
  input  logic [DATA_LEN-1:0] ld_raw,
  output logic [DATA_LEN-1:0] ld_data
);

  logic [DATA_LEN-1:0] shifted;

  always_comb begin
    st_wdata = '0;
    st_wstrb = '0;
    case (store_type)
      SB: begin
        st_wdata = {STRB_LEN{st_data[7:0]}};
        st_wstrb = STRB_LEN'(1) << st_off;
      end
      SH: begin
        st_wdata = {(STRB_LEN/2){st_data[15:0]}};
        st_wstrb = STRB_LEN'(3) << st_off;
      end
      SW: begin
        st_wdata = {(DATA_LEN/32){st_data[31:0]}};
        st_wstrb = STRB_LEN'(4'hF) << st_off;
      end
      default: ;
    endcase
  end

  // Sized casts of signed slices give sign extension to the full data width.
  always_comb begin
    shifted = ld_raw >> {ld_off, 3'b000};
    ld_data = '0;
    case (load_type)
      LB:      ld_data = DATA_LEN'($signed(shifted[7:0]));
      LBU:     ld_data = DATA_LEN'(shifted[7:0]);
      LH:      ld_data = DATA_LEN'($signed(shifted[15:0]));
      LHU:     ld_data = DATA_LEN'(shifted[15:0]);
      LW:      ld_data = DATA_LEN'($signed(shifted[31:0]));
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_22041211_lsu_hs.sv
// Load/store unit between EXU and WBU with valid/ready on the upstream, split
// memory request/response and writeback sides.
module ysyx_22041211_lsu_hs
  import ysyx_22041211_lsu_hs_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  localparam int STRB_LEN = DATA_LEN / 8,
  localparam int OFF_LEN = $clog2(STRB_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic                req_wen_o,
  output logic [ADDR_LEN-1:0] req_addr_o,
  output logic [DATA_LEN-1:0] req_wdata_o,
  output logic [STRB_LEN-1:0] req_wstrb_o,
  input  logic                resp_valid_i,
  output logic                resp_ready_o,
  input  logic [DATA_LEN-1:0] resp_rdata_i,
  input  logic                resp_err_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                memory_inst_o,
  output logic                misalign_o,
  output logic                access_err_o
);

  // Every port is valid/ready: a transfer happens on a rising edge where both
  // are high, and the sender keeps valid and its payload stable until then.

  lsu_state_e          state;
  logic [2:0]          ld_type_q;
  logic [OFF_LEN-1:0]  off_q;

  logic                in_is_load;
  logic [2:0]          in_ld;
  logic [1:0]          in_st;
  logic                in_mem;
  logic                in_misalign;
  logic [ADDR_LEN-1:0] in_addr;
  logic [DATA_LEN-1:0] st_wdata;
  logic [STRB_LEN-1:0] st_wstrb;
  logic [DATA_LEN-1:0] ld_data;

  // A valid load encoding wins if both encodings are set; unknown codes are non-memory.
  always_comb begin
    in_is_load  = is_load(load_type_i);
    in_ld       = in_is_load ? load_type_i : LOAD_NONE;
    in_st       = in_is_load ? STORE_NONE : store_type_i;
    in_mem      = in_is_load || (in_st != STORE_NONE);
    in_misalign = is_misaligned(in_ld, in_st, alu_result_i[1:0]);
    in_addr     = ADDR_LEN'(alu_result_i);
  end

  ysyx_22041211_lsu_align #(.DATA_LEN(DATA_LEN)) u_align (
    .st_off     (alu_result_i[OFF_LEN-1:0]),
    .store_type (in_st),
    .st_data    (mem_wdata_i),
    .st_wdata   (st_wdata),
    .st_wstrb   (st_wstrb),
    .ld_off     (off_q),
    .load_type  (ld_type_q),
    .ld_raw     (resp_rdata_i),
    .ld_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ld_type_q     <= LOAD_NONE;
      off_q         <= '0;
      in_ready_o    <= 1'b1;
      req_valid_o   <= 1'b0;
      req_wen_o     <= 1'b0;
      req_addr_o    <= '0;
      req_wdata_o   <= '0;
      req_wstrb_o   <= '0;
      resp_ready_o  <= 1'b0;
      out_valid_o   <= 1'b0;
      wd_o          <= 1'b0;
      wreg_o        <= '0;
      wdata_o       <= '0;
      csr_wdata_o   <= '0;
      memory_inst_o <= 1'b0;
      misalign_o    <= 1'b0;
      access_err_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            in_ready_o    <= 1'b0;
            ld_type_q     <= in_ld;
            off_q         <= alu_result_i[OFF_LEN-1:0];
            wreg_o        <= wreg_i;
            wdata_o       <= alu_result_i;
            csr_wdata_o   <= csr_wdata_i;
            memory_inst_o <= in_mem;
            wd_o          <= wd_i && !(in_mem && in_misalign);
            if (!in_mem || in_misalign) begin
              misalign_o  <= in_mem && in_misalign;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              req_valid_o <= 1'b1;
              req_wen_o   <= (in_st != STORE_NONE);
              req_addr_o  <= {in_addr[ADDR_LEN-1:OFF_LEN], {OFF_LEN{1'b0}}};
              req_wdata_o <= st_wdata;
              req_wstrb_o <= st_wstrb;
              state       <= REQ;
            end
          end
        end
        REQ: begin
          if (req_ready_i) begin
            req_valid_o  <= 1'b0;
            resp_ready_o <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (resp_valid_i) begin
            resp_ready_o <= 1'b0;
            access_err_o <= resp_err_i;
            if (resp_err_i) wd_o <= 1'b0;
            if (ld_type_q != LOAD_NONE) wdata_o <= ld_data;
            out_valid_o  <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            out_valid_o   <= 1'b0;
            misalign_o    <= 1'b0;
            access_err_o  <= 1'b0;
            memory_inst_o <= 1'b0;
            in_ready_o    <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
